mul6_err_sweeper: RTL and testbench
===================================

MUL6_ERR_SWEEPER -- requirements
Module: mul6_err_sweeper

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, range 1..15: clock cycles each operand pair is held on the multiplier-under-test before its product is sampled.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1: begin a sweep; sampled in IDLE or DONE only.
REQ-005 The block SHALL have port abort, input, 1: cancel a sweep in progress.
REQ-006 The block SHALL have port dut_a, output, 6: operand A to the 6x6 approximate multiplier under test, driven from a register.
REQ-007 The block SHALL have port dut_b, output, 6: operand B to the multiplier under test, driven from a register.
REQ-008 The block SHALL have port dut_p, input, 12: combinational 12-bit product returned by the multiplier under test.
REQ-009 The block SHALL have port busy, output, 1: high in RUN and FLUSH.
REQ-010 The block SHALL have port done, output, 1: high in DONE.
REQ-011 The block SHALL have port err_cnt, output, 13: number of operand pairs with dut_p != exact product.
REQ-012 The block SHALL have port err_sum, output, 24: sum of |exact - dut_p| over all pairs.
REQ-013 The block SHALL have port err_max, output, 12: worst-case absolute error.
REQ-014 The block SHALL have ports wce_a and wce_b, output, 6 each: operands of the first pair reaching err_max.

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN, FLUSH and DONE.
REQ-016 The block SHALL make these transitions: IDLE/DONE + start -> RUN; RUN -> FLUSH after the sample of index 4095; FLUSH -> DONE after one cycle; RUN/FLUSH + abort -> IDLE.
REQ-017 On the edge that takes start into RUN, the block SHALL clear the 12-bit index idx, the hold counter, the capture-valid flag and all result outputs.
REQ-018 In RUN, the block SHALL drive dut_a = idx[11:6] and dut_b = idx[5:0], so A is the major operand and B the minor operand.
REQ-019 In RUN, a hold counter SHALL count 0..SETTLE-1; at SETTLE-1 the block SHALL capture dut_p, the exact 12-bit product dut_a*dut_b and the operands into a capture stage, set the capture-valid flag, increment idx and reset the hold counter.
REQ-020 The accumulate stage SHALL process each valid capture on the following edge, computing diff = |exact - dut_p| as unsigned 12-bit via a 13-bit signed difference.
REQ-021 On each accumulated capture: diff != 0 SHALL increment err_cnt; err_sum SHALL add diff; diff > err_max (strict) SHALL update err_max, wce_a and wce_b, so ties keep the first occurrence.
REQ-022 No counter SHALL saturate or wrap; the widths hold the worst case (4096 errors, sum < 2^24).
REQ-023 FLUSH SHALL accumulate the final capture; the same edge SHALL set done.
REQ-024 The start-sampling edge is edge 0; done SHALL first be high after edge 4096*SETTLE+1.
REQ-025 In IDLE and DONE, dut_a and dut_b SHALL be 0 and results SHALL hold their values.
REQ-026 start SHALL be ignored while busy.
REQ-027 abort SHALL be ignored in IDLE and DONE; in IDLE, start and abort in the same cycle SHALL start a sweep.
REQ-028 In RUN or FLUSH, abort SHALL win over any other event: IDLE on the next edge, done=0, dut operands=0, partial results held, pending capture discarded.
REQ-029 start in DONE SHALL clear the results and begin a new sweep.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, idx=0, hold counter=0, capture-valid flag=0, dut_a=dut_b=0, busy=0, done=0, and err_cnt, err_sum, err_max, wce_a, wce_b all 0, in any state including mid-sweep.
REQ-031 After rst_n deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-032 Exact-multiplier model, SETTLE=1, start pulse -> done after edge 4097; err_cnt=0, err_sum=0, err_max=0, wce_a=wce_b=0.
REQ-033 Model dut_p=0 -> err_cnt=3969, err_sum=4064256, err_max=3969, wce_a=63, wce_b=63.
REQ-034 Model exact product with bit0 forced 0 -> err_cnt=1024, err_sum=1024, err_max=1, wce_a=1, wce_b=1.
REQ-035 abort at edge 100 of RUN -> IDLE next edge, busy=0, done=0, dut_a=dut_b=0; a fresh start then reproduces the REQ-032 results.
REQ-036 SETTLE=3 with a model whose product is valid 2 cycles after its operands change -> done after edge 12289; results as REQ-034 when bit0 is forced 0.
REQ-037 rst_n pulsed low mid-RUN -> all outputs 0 asynchronously with no clock edge; start after release -> full correct sweep.

Source files
------------

// File: rtl/mul6_err_sweeper.sv
// Exhaustive error characteriser for a 6x6 approximate multiplier: sweeps all 4096
// operand pairs and accumulates error count, error sum, worst-case error and its operands.
module mul6_err_sweeper #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [5:0]  dut_a,
  output logic [5:0]  dut_b,
  input  logic [11:0] dut_p,
  output logic        busy,
  output logic        done,
  output logic [12:0] err_cnt,
  output logic [23:0] err_sum,
  output logic [11:0] err_max,
  output logic [5:0]  wce_a,
  output logic [5:0]  wce_b
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e      state_q, state_d;
  logic [11:0] idx_q;
  logic [3:0]  hold_q;
  logic        cap_vld_q;
  logic [11:0] cap_p_q, cap_x_q;
  logic [5:0]  cap_a_q, cap_b_q;
  logic [5:0]  dut_a_q, dut_b_q;
  logic [12:0] err_cnt_q;
  logic [23:0] err_sum_q;
  logic [11:0] err_max_q;
  logic [5:0]  wce_a_q, wce_b_q;

  logic        active, start_go, abort_go, sample, last, accum;
  logic [11:0] idx_d, diff_d;

  function automatic logic [11:0] exact_prod(input logic [5:0] a, input logic [5:0] b);
    return {6'b0, a} * {6'b0, b};
  endfunction

  // Absolute error via a 13-bit signed difference so either ordering is representable.
  function automatic logic [11:0] abs_diff(input logic [11:0] x, input logic [11:0] p);
    logic signed [12:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, p});
    return (d < 0) ? 12'(-d) : 12'(d);
  endfunction

  assign active   = (state_q == RUN) || (state_q == FLUSH);
  assign start_go = start && ((state_q == IDLE) || (state_q == DONE));
  assign abort_go = abort && active;
  assign sample   = (state_q == RUN) && (hold_q == 4'(SETTLE - 1)) && !abort_go;
  assign last     = sample && (idx_q == 12'hFFF);
  assign accum    = cap_vld_q && active && !abort_go;
  assign idx_d    = idx_q + 12'd1;
  assign diff_d   = abs_diff(cap_x_q, cap_p_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (abort) state_d = IDLE;
                  else if (last) state_d = FLUSH;
      FLUSH:      if (abort) state_d = IDLE;
                  else state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = active;
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      hold_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_p_q   <= '0;
      cap_x_q   <= '0;
      cap_a_q   <= '0;
      cap_b_q   <= '0;
      dut_a_q   <= '0;
      dut_b_q   <= '0;
      err_cnt_q <= '0;
      err_sum_q <= '0;
      err_max_q <= '0;
      wce_a_q   <= '0;
      wce_b_q   <= '0;
    end else if (start_go) begin
      idx_q     <= '0;
      hold_q    <= '0;
      cap_vld_q <= 1'b0;
      dut_a_q   <= '0;
      dut_b_q   <= '0;
      err_cnt_q <= '0;
      err_sum_q <= '0;
      err_max_q <= '0;
      wce_a_q   <= '0;
      wce_b_q   <= '0;
    end else if (abort_go) begin
      // Partial results stay visible; the in-flight capture is dropped.
      idx_q     <= '0;
      hold_q    <= '0;
      cap_vld_q <= 1'b0;
      dut_a_q   <= '0;
      dut_b_q   <= '0;
    end else begin
      cap_vld_q <= sample;
      if (state_q == RUN) begin
        if (sample) begin
          cap_p_q <= dut_p;
          cap_x_q <= exact_prod(dut_a_q, dut_b_q);
          cap_a_q <= dut_a_q;
          cap_b_q <= dut_b_q;
          idx_q   <= idx_d;
          hold_q  <= '0;
          dut_a_q <= idx_d[11:6];
          dut_b_q <= idx_d[5:0];
        end else begin
          hold_q <= hold_q + 4'd1;
        end
      end
      // Accumulate stage; strict compare keeps the first worst-case pair.
      if (accum) begin
        if (diff_d != 12'd0) err_cnt_q <= err_cnt_q + 13'd1;
        err_sum_q <= err_sum_q + {12'b0, diff_d};
        if (diff_d > err_max_q) begin
          err_max_q <= diff_d;
          wce_a_q   <= cap_a_q;
          wce_b_q   <= cap_b_q;
        end
      end
    end
  end

  assign dut_a   = dut_a_q;
  assign dut_b   = dut_b_q;
  assign err_cnt = err_cnt_q;
  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
  assign wce_a   = wce_a_q;
  assign wce_b   = wce_b_q;

endmodule

// File: tb/tb_mul6_err_sweeper.sv
// Bench for mul6_err_sweeper: a SETTLE=1 instance with a selectable combinational
// multiplier model and a SETTLE=3 instance driving a two-cycle-latency model.
module tb_mul6_err_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start1, abort1, start3, abort3;
  logic [5:0]  a1, b1, a3, b3, wa1, wb1, wa3, wb3;
  logic [11:0] p1, p3, mx1, mx3;
  logic        busy1, done1, busy3, done3;
  logic [12:0] c1, c3;
  logic [23:0] s1, s3;
  int          mode;
  int          sel;
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    int          mode;
    logic [12:0] cnt;
    logic [23:0] sum;
    logic [11:0] mx;
    logic [5:0]  wa;
    logic [5:0]  wb;
    int          lat;
  } vec_t;

  vec_t vecs[4];
  vec_t sb[$];

  mul6_err_sweeper #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .dut_a(a1), .dut_b(b1), .dut_p(p1), .busy(busy1), .done(done1),
    .err_cnt(c1), .err_sum(s1), .err_max(mx1), .wce_a(wa1), .wce_b(wb1));

  mul6_err_sweeper #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .dut_a(a3), .dut_b(b3), .dut_p(p3), .busy(busy3), .done(done3),
    .err_cnt(c3), .err_sum(s3), .err_max(mx3), .wce_a(wa3), .wce_b(wb3));

  function automatic logic [11:0] model_p(int m, logic [5:0] a, logic [5:0] b);
    logic [11:0] x;
    x = {6'b0, a} * {6'b0, b};
    case (m)
      0:       return x;
      1:       return 12'd0;
      2:       return x & 12'hFFE;
      default: return x ^ {9'b0, a[2:0] ^ b[2:0]};
    endcase
  endfunction

  always_comb p1 = model_p(mode, a1, b1);

  logic [11:0] r1, r2;
  always @(posedge clk) begin
    r1 <= model_p(2, a3, b3);
    r2 <= r1;
  end
  assign p3 = r2;

  logic        done_s, busy_s;
  logic [5:0]  a_s, b_s, wa_s, wb_s;
  logic [12:0] c_s;
  logic [23:0] s_s;
  logic [11:0] mx_s;
  always_comb begin
    done_s = (sel != 0) ? done3 : done1;
    busy_s = (sel != 0) ? busy3 : busy1;
    a_s    = (sel != 0) ? a3 : a1;
    b_s    = (sel != 0) ? b3 : b1;
    c_s    = (sel != 0) ? c3 : c1;
    s_s    = (sel != 0) ? s3 : s1;
    mx_s   = (sel != 0) ? mx3 : mx1;
    wa_s   = (sel != 0) ? wa3 : wa1;
    wb_s   = (sel != 0) ? wb3 : wb1;
  end

  // Reference sweep over the first n pairs in A-major order.
  function automatic vec_t model_sweep(int m, int n);
    vec_t v;
    v.mode = m; v.cnt = '0; v.sum = '0; v.mx = '0; v.wa = '0; v.wb = '0; v.lat = 4097;
    for (int i = 0; i < n; i++) begin
      logic [5:0]  a, b;
      logic [11:0] x, p, d;
      a = 6'(i >> 6);
      b = 6'(i);
      x = {6'b0, a} * {6'b0, b};
      p = model_p(m, a, b);
      d = (x >= p) ? x - p : p - x;
      if (d != 12'd0) v.cnt = v.cnt + 13'd1;
      v.sum = v.sum + {12'b0, d};
      if (d > v.mx) begin
        v.mx = d; v.wa = a; v.wb = b;
      end
    end
    return v;
  endfunction

  task automatic chk(string nm, int act, int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic check_res(string tag, vec_t e);
    chk({tag, ".err_cnt"}, int'(c_s), int'(e.cnt));
    chk({tag, ".err_sum"}, int'(s_s), int'(e.sum));
    chk({tag, ".err_max"}, int'(mx_s), int'(e.mx));
    chk({tag, ".wce_a"}, int'(wa_s), int'(e.wa));
    chk({tag, ".wce_b"}, int'(wb_s), int'(e.wb));
  endtask

  task automatic drive_start(int s, logic v);
    if (s != 0) start3 = v; else start1 = v;
  endtask

  // Called just after edge 0; returns number of edges until done is seen high.
  task automatic wait_done(int s, int poke, output int lat);
    lat = 0;
    while (!done_s && lat < 20000) begin
      @(posedge clk); #1;
      lat++;
      drive_start(s, lat == poke);
    end
    drive_start(s, 1'b0);
  endtask

  task automatic run_sweep(int s, int poke, output int lat);
    @(negedge clk); drive_start(s, 1'b1);
    @(posedge clk); #1; drive_start(s, 1'b0);
    wait_done(s, poke, lat);
  endtask

  initial begin
    int   lat;
    vec_t e;
    rst_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    mode = 0; sel = 0;

    vecs[0] = '{mode: 0, cnt: 13'd0,    sum: 24'd0,       mx: 12'd0,    wa: 6'd0,  wb: 6'd0,  lat: 4097};
    vecs[1] = '{mode: 1, cnt: 13'd3969, sum: 24'd4064256, mx: 12'd3969, wa: 6'd63, wb: 6'd63, lat: 4097};
    vecs[2] = '{mode: 2, cnt: 13'd1024, sum: 24'd1024,    mx: 12'd1,    wa: 6'd1,  wb: 6'd1,  lat: 4097};
    vecs[3] = model_sweep(3, 4096);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.busy", int'(busy1), 0);
    chk("rst.done", int'(done1), 0);
    chk("rst.dut_a", int'(a1), 0);
    check_res("rst", vecs[0]);

    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      sb.push_back(vecs[i]);
      run_sweep(0, 0, lat);
      e = sb.pop_front();
      chk($sformatf("vec%0d.latency", i), lat, e.lat);
      check_res($sformatf("vec%0d", i), e);
      chk($sformatf("vec%0d.busy", i), int'(busy1), 0);
      chk($sformatf("vec%0d.dut_ab", i), int'({a1, b1}), 0);
    end

    // Abort sampled at edge 100: 98 pairs accumulated, the pending capture dropped.
    mode = 1;
    sb.push_back(model_sweep(1, 98));
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (99) @(posedge clk);
    #1 abort1 = 1'b1;
    @(posedge clk); #1; abort1 = 1'b0;
    e = sb.pop_front();
    chk("abort.busy", int'(busy1), 0);
    chk("abort.done", int'(done1), 0);
    chk("abort.dut_ab", int'({a1, b1}), 0);
    check_res("abort", e);

    abort1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 abort1 = 1'b0;
    chk("idle_abort.busy", int'(busy1), 0);
    check_res("idle_abort", e);

    // Start and abort together in IDLE still launches a fresh sweep.
    mode = 0;
    sb.push_back(vecs[0]);
    @(negedge clk); start1 = 1'b1; abort1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0; abort1 = 1'b0;
    chk("start_abort.busy", int'(busy1), 1);
    wait_done(0, 0, lat);
    e = sb.pop_front();
    chk("restart.latency", lat, 4097);
    check_res("restart", e);

    // Asynchronous reset mid-sweep, between clock edges.
    mode = 1;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (1500) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", int'(busy1), 0);
    chk("arst.done", int'(done1), 0);
    chk("arst.dut_ab", int'({a1, b1}), 0);
    check_res("arst", vecs[0]);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_release.busy", int'(busy1), 0);
    sb.push_back(vecs[1]);
    run_sweep(0, 0, lat);
    e = sb.pop_front();
    chk("after_rst.latency", lat, 4097);
    check_res("after_rst", e);

    // SETTLE=3 with a delayed product; a start pulse mid-sweep must be ignored.
    sel = 1;
    e = vecs[2];
    e.lat = 12289;
    sb.push_back(e);
    run_sweep(1, 500, lat);
    e = sb.pop_front();
    chk("settle3.latency", lat, e.lat);
    check_res("settle3", e);
    chk("settle3.busy", int'(busy_s), 0);
    chk("settle3.dut_ab", int'({a_s, b_s}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
